cl_mem_stage: RTL and testbench

//  Memory-stage controller downstream of the instruction decoder; consumes its
//  is_load/is_store/is_mem/is_byte/op_writes_rf flags plus ALU address/data.

---
 rtl/cl_mem_stage.sv | 143 ++++++++++++++
 tb/tb_cl_mem_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cl_mem_stage.sv
// Memory-stage controller: one outstanding data-memory request at a time, byte-lane
// handling, load-response timeout, and a registered writeback packet for every op.
module cl_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        is_load_op_i,
  input  logic        is_store_op_i,
  input  logic        is_mem_op_i,
  input  logic        is_byte_op_i,
  input  logic        op_writes_rf_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_wen_o,
  output logic [3:0]  mem_mask_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_en_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       off_q;
  logic             byte_q;
  logic [4:0]       rd_q;

  logic       accept;
  logic       mem_op;
  logic       misaligned;
  logic [1:0] off;
  logic [7:0] rbyte;

  always_comb begin
    ready_o     = (state == IDLE);
    mem_valid_o = (state == REQ);
    accept      = valid_i & ready_o;
    // a mem flag without load or store is an illegal encoding and falls through as ALU op
    mem_op      = is_mem_op_i & (is_load_op_i | is_store_op_i);
    off         = alu_result_i[1:0];
    misaligned  = ~is_byte_op_i & (off != 2'b00);
    case (off_q)
      2'd0:    rbyte = mem_rdata_i[7:0];
      2'd1:    rbyte = mem_rdata_i[15:8];
      2'd2:    rbyte = mem_rdata_i[23:16];
      default: rbyte = mem_rdata_i[31:24];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      off_q       <= '0;
      byte_q      <= 1'b0;
      rd_q        <= '0;
      mem_wen_o   <= 1'b0;
      mem_mask_o  <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      wb_valid_o  <= 1'b0;
      wb_en_o     <= 1'b0;
      wb_rd_o     <= '0;
      wb_data_o   <= '0;
      err_o       <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      wb_en_o    <= 1'b0;
      err_o      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!mem_op) begin
              wb_valid_o <= 1'b1;
              wb_en_o    <= op_writes_rf_i;
              wb_rd_o    <= rd_addr_i;
              wb_data_o  <= alu_result_i;
            end else if (misaligned) begin
              wb_valid_o <= 1'b1;
              err_o      <= 1'b1;
              wb_rd_o    <= rd_addr_i;
            end else begin
              mem_wen_o   <= is_store_op_i;
              mem_mask_o  <= is_byte_op_i ? (4'b0001 << off) : 4'b1111;
              mem_addr_o  <= {alu_result_i[31:2], 2'b00};
              mem_wdata_o <= is_byte_op_i ? {4{store_data_i[7:0]}} : store_data_i;
              off_q       <= off;
              byte_q      <= is_byte_op_i;
              rd_q        <= rd_addr_i;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ready_i) begin
            cnt <= '0;
            if (mem_wen_o) begin
              wb_valid_o <= 1'b1;
              wb_rd_o    <= rd_q;
              state      <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            wb_valid_o <= 1'b1;
            wb_en_o    <= 1'b1;
            wb_rd_o    <= rd_q;
            wb_data_o  <= byte_q ? {24'd0, rbyte} : mem_rdata_i;
            state      <= IDLE;
          end else if (cnt == CNT_LAST) begin
            wb_valid_o <= 1'b1;
            err_o      <= 1'b1;
            wb_rd_o    <= rd_q;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_mem_stage.sv
// Directed plus randomized bench for cl_mem_stage; expected packets and memory
// requests come from a transaction-level model of the memory-stage rules.
module tb_cl_mem_stage;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, ready_o;
  logic        is_load_op_i, is_store_op_i, is_mem_op_i, is_byte_op_i, op_writes_rf_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        mem_valid_o, mem_ready_i, mem_wen_o;
  logic [3:0]  mem_mask_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o, wb_en_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  cl_mem_stage #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset),
    .valid_i(valid_i), .ready_o(ready_o),
    .is_load_op_i(is_load_op_i), .is_store_op_i(is_store_op_i),
    .is_mem_op_i(is_mem_op_i), .is_byte_op_i(is_byte_op_i),
    .op_writes_rf_i(op_writes_rf_i), .rd_addr_i(rd_addr_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_wen_o(mem_wen_o),
    .mem_mask_o(mem_mask_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_en_o(wb_en_o), .wb_rd_o(wb_rd_o),
    .wb_data_o(wb_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction from accept to writeback packet. rsp_dly counts WAIT
  // cycles until rvalid (1..TIMEOUT); anything else means the memory never answers.
  task automatic run_op(input logic ld, input logic st, input logic mem, input logic byt,
                        input logic wrf, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] sd, input int rdy_dly, input int rsp_dly,
                        input logic [31:0] rdata);
    logic [31:0] exp_addr, exp_mask, exp_wdata, exp_data;
    int lane;
    lane      = int'(a % 4);
    exp_addr  = a - (a % 4);
    exp_mask  = byt ? (32'd1 << lane) : 32'hF;
    exp_wdata = byt ? (32'(sd[7:0]) * 32'h0101_0101) : sd;
    exp_data  = byt ? ((rdata >> (8 * lane)) & 32'hFF) : rdata;

    check("ready_idle", 32'(ready_o), 1);
    valid_i = 1'b1; is_load_op_i = ld; is_store_op_i = st; is_mem_op_i = mem;
    is_byte_op_i = byt; op_writes_rf_i = wrf; rd_addr_i = rd;
    alu_result_i = a; store_data_i = sd;
    @(negedge clk);
    valid_i = 1'b0;

    if (!(mem && (ld || st))) begin
      check("alu_wb_valid", 32'(wb_valid_o), 1);
      check("alu_wb_en", 32'(wb_en_o), 32'(wrf));
      check("alu_wb_rd", 32'(wb_rd_o), 32'(rd));
      check("alu_wb_data", wb_data_o, a);
      check("alu_err", 32'(err_o), 0);
      return;
    end
    if (!byt && lane != 0) begin
      check("mis_mem_valid", 32'(mem_valid_o), 0);
      check("mis_err", 32'(err_o), 1);
      check("mis_wb_valid", 32'(wb_valid_o), 1);
      check("mis_wb_en", 32'(wb_en_o), 0);
      check("mis_ready", 32'(ready_o), 1);
      return;
    end

    for (int i = 0; i <= rdy_dly; i++) begin
      check("req_valid", 32'(mem_valid_o), 1);
      check("req_ready_o", 32'(ready_o), 0);
      check("req_addr", mem_addr_o, exp_addr);
      check("req_mask", 32'(mem_mask_o), exp_mask);
      check("req_wen", 32'(mem_wen_o), 32'(st));
      if (st) check("req_wdata", mem_wdata_o, exp_wdata);
      mem_ready_i  = (i == rdy_dly);
      mem_rvalid_i = 1'($urandom);
      mem_rdata_i  = $urandom;
      @(negedge clk);
    end
    mem_ready_i  = 1'b0;
    mem_rvalid_i = 1'b0;

    if (st) begin
      check("st_wb_valid", 32'(wb_valid_o), 1);
      check("st_wb_en", 32'(wb_en_o), 0);
      check("st_err", 32'(err_o), 0);
      check("st_ready", 32'(ready_o), 1);
      return;
    end

    for (int w = 1; w <= TIMEOUT; w++) begin
      check("wait_wb_valid", 32'(wb_valid_o), 0);
      check("wait_ready_o", 32'(ready_o), 0);
      mem_rvalid_i = (w == rsp_dly);
      mem_rdata_i  = (w == rsp_dly) ? rdata : $urandom;
      @(negedge clk);
      if (w == rsp_dly) break;
    end
    mem_rvalid_i = 1'b0;

    if (rsp_dly >= 1 && rsp_dly <= TIMEOUT) begin
      check("ld_wb_valid", 32'(wb_valid_o), 1);
      check("ld_wb_en", 32'(wb_en_o), 1);
      check("ld_wb_rd", 32'(wb_rd_o), 32'(rd));
      check("ld_wb_data", wb_data_o, exp_data);
      check("ld_err", 32'(err_o), 0);
    end else begin
      check("to_err", 32'(err_o), 1);
      check("to_wb_valid", 32'(wb_valid_o), 1);
      check("to_wb_en", 32'(wb_en_o), 0);
      check("to_ready", 32'(ready_o), 1);
    end
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    logic byt;

    reset = 1'b1;
    valid_i = 0; is_load_op_i = 0; is_store_op_i = 0; is_mem_op_i = 0;
    is_byte_op_i = 0; op_writes_rf_i = 0; rd_addr_i = '0;
    alu_result_i = '0; store_data_i = '0;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    #12;
    check("rst_ready", 32'(ready_o), 1);
    check("rst_mem_valid", 32'(mem_valid_o), 0);
    check("rst_wb_valid", 32'(wb_valid_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_mask", 32'(mem_mask_o), 0);
    check("rst_wb_data", wb_data_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // ADDU, then an idle cycle where the packet data must hold
    run_op(0, 0, 0, 0, 1, 5'd3, 32'h1234, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check("hold_wb_valid", 32'(wb_valid_o), 0);
    check("hold_wb_data", wb_data_o, 32'h1234);
    check("hold_wb_rd", 32'(wb_rd_o), 3);

    run_op(1, 0, 1, 1, 1, 5'd7, 32'h102, 32'h0, 2, 3, 32'hAABB_CCDD);  // LBU
    run_op(0, 1, 1, 1, 0, 5'd0, 32'h3, 32'h5A, 0, 0, 32'h0);           // SB
    run_op(1, 0, 1, 0, 1, 5'd9, 32'h6, 32'h0, 0, 0, 32'h0);            // LW misaligned
    run_op(0, 0, 1, 0, 1, 5'd4, 32'h77, 32'h0, 0, 0, 32'h0);           // illegal flags
    run_op(1, 0, 1, 0, 1, 5'd12, 32'h80, 32'h0, 1, TIMEOUT, 32'hDEAD_BEEF);
    run_op(0, 1, 1, 0, 0, 5'd0, 32'h44, 32'hCAFE_F00D, 3, 0, 32'h0);   // SW

    // load timeout followed by a late, ignored response
    run_op(1, 0, 1, 0, 1, 5'd5, 32'h40, 32'h0, 0, 0, 32'h0);
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("late_wb_valid", 32'(wb_valid_o), 0);
    check("late_err", 32'(err_o), 0);
    check("late_ready", 32'(ready_o), 1);

    // asynchronous reset while waiting for a load response
    valid_i = 1'b1; is_load_op_i = 1; is_store_op_i = 0; is_mem_op_i = 1;
    is_byte_op_i = 0; op_writes_rf_i = 1; rd_addr_i = 5'd6; alu_result_i = 32'h200;
    @(negedge clk);
    valid_i = 1'b0; mem_ready_i = 1'b1;
    @(negedge clk);
    mem_ready_i = 1'b0;
    @(negedge clk);
    check("pre_rst_ready", 32'(ready_o), 0);
    #2 reset = 1'b1;
    #1;
    check("arst_ready", 32'(ready_o), 1);
    check("arst_mem_valid", 32'(mem_valid_o), 0);
    check("arst_wb_valid", 32'(wb_valid_o), 0);
    check("arst_wb_data", wb_data_o, 0);
    check("arst_mask", 32'(mem_mask_o), 0);
    @(negedge clk);
    reset = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_4444;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    check("arst_late_wb", 32'(wb_valid_o), 0);
    check("arst_late_ready", 32'(ready_o), 1);

    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom_range(0, 3));
      byt  = 1'($urandom);
      a    = $urandom;
      if (!byt && $urandom_range(0, 3) != 0) a = a - (a % 4);
      case (kind)
        0: run_op(0, 0, 0, byt, 1'($urandom), 5'($urandom), a, $urandom, 0, 0, 32'h0);
        1: run_op(1, 0, 1, byt, 1, 5'($urandom), a, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), $urandom);
        2: run_op(0, 1, 1, byt, 0, 5'($urandom), a, $urandom,
                  int'($urandom_range(0, 3)), 0, 32'h0);
        default: run_op(0, 0, 1, byt, 1'($urandom), 5'($urandom), a, $urandom, 0, 0, 32'h0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
